// File: rtl/siphash_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : siphash_stream_core
// Purpose  : Streaming SipHash-c-d core, one 64-bit message beat per handshake,
//            64- or 128-bit digest.
// Revision : 1.0
// ============================================================================
module siphash_stream_core #(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4,
  parameter int UNROLL   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         long,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  input  logic [3:0]   in_bytes,
  output logic         busy,
  output logic [127:0] digest,
  output logic         digest_valid
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ACCEPT   = 4'd1,
    COMP     = 4'd2,
    COMP_END = 4'd3,
    PAD      = 4'd4,
    FIN0     = 4'd5,
    ROUND0   = 4'd6,
    FIN1     = 4'd7,
    ROUND1   = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [63:0] c_init0   = 64'h736f6d6570736575;
  localparam logic [63:0] c_init1   = 64'h646f72616e646f6d;
  localparam logic [63:0] c_init2   = 64'h6c7967656e657261;
  localparam logic [63:0] c_init3   = 64'h7465646279746573;
  localparam logic [3:0]  c_crounds = 4'(C_ROUNDS);
  localparam logic [3:0]  c_drounds = 4'(D_ROUNDS);

  // State vector packed as {v3, v2, v1, v0}.
  function automatic logic [255:0] sip_round(input logic [255:0] v);
    logic [63:0] a, b, c, d;
    a = v[63:0];
    b = v[127:64];
    c = v[191:128];
    d = v[255:192];
    a = a + b; b = {b[50:0], b[63:51]}; b = b ^ a; a = {a[31:0], a[63:32]};
    c = c + d; d = {d[47:0], d[63:48]}; d = d ^ c;
    a = a + d; d = {d[42:0], d[63:43]}; d = d ^ a;
    c = c + b; b = {b[46:0], b[63:47]}; b = b ^ c; c = {c[31:0], c[63:32]};
    return {d, c, b, a};
  endfunction

  state_t       r_state, w_state_next;
  logic [63:0]  r_v0, r_v1, r_v2, r_v3, r_m;
  logic [7:0]   r_len;
  logic [3:0]   r_rnd;
  logic         r_long, r_blk_last, r_need_pad;
  logic [127:0] r_digest;
  logic         r_digest_valid;

  logic [255:0] w_r1, w_r2;
  logic         w_two, w_rounds_done;
  logic [3:0]   w_step, w_nbytes;
  logic [7:0]   w_len_next;
  logic [63:0]  w_m, w_vxor;

  assign w_r1 = sip_round({r_v3, r_v2, r_v1, r_v0});

  generate
    if (UNROLL == 2) begin : g_unroll2
      assign w_r2 = sip_round(w_r1);
    end else begin : g_unroll1
      assign w_r2 = w_r1;
    end
  endgenerate

  // With two rounds per cycle an odd round count finishes with a single round.
  assign w_two         = (UNROLL == 2) && (r_rnd >= 4'd2);
  assign w_step        = w_two ? 4'd2 : 4'd1;
  assign w_rounds_done = (r_rnd <= w_step);
  assign w_vxor        = r_v0 ^ r_v1 ^ r_v2 ^ r_v3;
  assign w_nbytes      = (in_last && (in_bytes < 4'd8)) ? in_bytes : 4'd8;
  assign w_len_next    = r_len + {4'd0, w_nbytes};

  always_comb begin
    w_m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < w_nbytes) w_m[8*i +: 8] = in_data[8*i +: 8];
    end
    if (w_nbytes < 4'd8) w_m[63:56] = w_len_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = (r_state != IDLE);
    case (r_state)
      IDLE:     if (start) w_state_next = ACCEPT;
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = COMP;
      end
      COMP:     if (w_rounds_done) w_state_next = COMP_END;
      COMP_END: begin
        if (!r_blk_last)     w_state_next = ACCEPT;
        else if (r_need_pad) w_state_next = PAD;
        else                 w_state_next = FIN0;
      end
      PAD:      w_state_next = COMP;
      FIN0:     w_state_next = ROUND0;
      ROUND0:   if (w_rounds_done) w_state_next = r_long ? FIN1 : DONE;
      FIN1:     w_state_next = ROUND1;
      ROUND1:   if (w_rounds_done) w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_v0           <= '0;
      r_v1           <= '0;
      r_v2           <= '0;
      r_v3           <= '0;
      r_m            <= '0;
      r_len          <= '0;
      r_rnd          <= '0;
      r_long         <= 1'b0;
      r_blk_last     <= 1'b0;
      r_need_pad     <= 1'b0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_v0           <= key[63:0]   ^ c_init0;
          r_v1           <= key[127:64] ^ c_init1 ^ (long ? 64'hee : 64'h0);
          r_v2           <= key[63:0]   ^ c_init2;
          r_v3           <= key[127:64] ^ c_init3;
          r_len          <= '0;
          r_long         <= long;
          r_blk_last     <= 1'b0;
          r_need_pad     <= 1'b0;
          r_digest_valid <= 1'b0;
        end
        ACCEPT: if (in_valid) begin
          r_v3       <= r_v3 ^ w_m;
          r_m        <= w_m;
          r_len      <= w_len_next;
          r_blk_last <= in_last;
          r_need_pad <= in_last && (w_nbytes == 4'd8);
          r_rnd      <= c_crounds;
        end
        COMP, ROUND0, ROUND1: begin
          {r_v3, r_v2, r_v1, r_v0} <= w_two ? w_r2 : w_r1;
          r_rnd <= r_rnd - w_step;
        end
        COMP_END: r_v0 <= r_v0 ^ r_m;
        // A message that ends on a full beat needs one extra length-only block.
        PAD: begin
          r_v3       <= r_v3 ^ {r_len, 56'd0};
          r_m        <= {r_len, 56'd0};
          r_need_pad <= 1'b0;
          r_rnd      <= c_crounds;
        end
        FIN0: begin
          r_v2  <= r_v2 ^ (r_long ? 64'hee : 64'hff);
          r_rnd <= c_drounds;
        end
        FIN1: begin
          r_digest[63:0] <= w_vxor;
          r_v1           <= r_v1 ^ 64'hdd;
          r_rnd          <= c_drounds;
        end
        DONE: begin
          if (r_long) r_digest[127:64] <= w_vxor;
          else        r_digest         <= {64'd0, w_vxor};
          r_digest_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_siphash_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_siphash_stream_core
// Purpose  : Randomised self-checking bench against a byte-level SipHash model.
// Revision : 1.0
// ============================================================================
module tb_siphash_stream_core;

  localparam logic [127:0] c_key_std = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, long, start, in_valid, in_last, sel;
  logic [127:0] key;
  logic [63:0]  in_data;
  logic [3:0]   in_bytes;
  logic         rdy_a, busy_a, dv_a, rdy_b, busy_b, dv_b;
  logic [127:0] dg_a, dg_b;
  logic         start_a, start_b, vld_a, vld_b;
  logic         in_ready, busy, digest_valid;
  logic [127:0] digest;

  // sel chooses which instance the stimulus drives and which outputs are observed.
  assign start_a      = start & ~sel;
  assign start_b      = start & sel;
  assign vld_a        = in_valid & ~sel;
  assign vld_b        = in_valid & sel;
  assign in_ready     = sel ? rdy_b : rdy_a;
  assign busy         = sel ? busy_b : busy_a;
  assign digest_valid = sel ? dv_b : dv_a;
  assign digest       = sel ? dg_b : dg_a;

  siphash_stream_core dut_a (
    .clk(clk), .reset_n(reset_n), .key(key), .long(long), .start(start_a),
    .in_valid(vld_a), .in_ready(rdy_a), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .busy(busy_a), .digest(dg_a), .digest_valid(dv_a)
  );

  siphash_stream_core #(.C_ROUNDS(3), .D_ROUNDS(4), .UNROLL(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .key(key), .long(long), .start(start_b),
    .in_valid(vld_b), .in_ready(rdy_b), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .busy(busy_b), .digest(dg_b), .digest_valid(dv_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  msg_q[$];
  logic [63:0] mv[4];

  function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
    return (x << s) | (x >> (64 - s));
  endfunction

  function automatic void sround();
    mv[0] = mv[0] + mv[1]; mv[1] = rotl(mv[1], 13); mv[1] ^= mv[0]; mv[0] = rotl(mv[0], 32);
    mv[2] = mv[2] + mv[3]; mv[3] = rotl(mv[3], 16); mv[3] ^= mv[2];
    mv[0] = mv[0] + mv[3]; mv[3] = rotl(mv[3], 21); mv[3] ^= mv[0];
    mv[2] = mv[2] + mv[1]; mv[1] = rotl(mv[1], 17); mv[1] ^= mv[2]; mv[2] = rotl(mv[2], 32);
  endfunction

  function automatic logic [127:0] ref_hash(input logic [127:0] k, input bit lg,
                                            input int c, input int d);
    logic [63:0] m, out0, out1;
    int n, full;
    n    = msg_q.size();
    full = n / 8;
    mv[0] = k[63:0]   ^ 64'h736f6d6570736575;
    mv[1] = k[127:64] ^ 64'h646f72616e646f6d ^ (lg ? 64'hee : 64'h0);
    mv[2] = k[63:0]   ^ 64'h6c7967656e657261;
    mv[3] = k[127:64] ^ 64'h7465646279746573;
    for (int w = 0; w <= full; w++) begin
      m = '0;
      if (w < full) begin
        for (int j = 0; j < 8; j++) m[8*j +: 8] = msg_q[8*w + j];
      end else begin
        for (int j = 0; j < n % 8; j++) m[8*j +: 8] = msg_q[8*w + j];
        m[63:56] = n[7:0];
      end
      mv[3] ^= m;
      for (int r = 0; r < c; r++) sround();
      mv[0] ^= m;
    end
    mv[2] ^= (lg ? 64'hee : 64'hff);
    for (int r = 0; r < d; r++) sround();
    out0 = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    if (!lg) return {64'd0, out0};
    mv[1] ^= 64'hdd;
    for (int r = 0; r < d; r++) sround();
    out1 = mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
    return {out1, out0};
  endfunction

  // Streams msg_q into the selected core and waits for its digest.
  task automatic run_msg(input logic [127:0] k, input bit lg, input bit stall, input bit poke,
                         output logic [127:0] dg, output int lat);
    int n, beats, t, rem;
    n     = msg_q.size();
    beats = (n == 0) ? 1 : (n + 7) / 8;
    lat   = 0;
    dg    = '0;
    @(negedge clk);
    key = k; long = lg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    long  = ~lg;
    for (int b = 0; b < beats; b++) begin
      if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
      rem      = n - 8*b;
      in_last  = (b == beats - 1);
      in_bytes = in_last ? 4'(rem) : 4'($urandom_range(0, 15));
      in_data  = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) if (8*b + j < n) in_data[8*j +: 8] = msg_q[8*b + j];
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
        n_checks++; n_fail++;
        $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'($urandom);
      in_data  = {$urandom, $urandom};
      if (poke) begin
        start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom}; long = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    while (digest_valid !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    if (lat >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL digest_timeout: digest_valid=%b, required 1", digest_valid);
    end
    dg = digest;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (digest !== 128'd0) begin n_fail++; $display("FAIL reset_digest: got %h, required 0", digest); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b, required 0", digest_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", in_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [127:0] dg;
    int lat;
    sel = 1'b0;
    msg_q.delete();
    run_msg(c_key_std, 1'b0, 1'b0, 1'b0, dg, lat);
    n_checks++; if (dg !== {64'd0, 64'h726fdb47dd0e0e31}) begin n_fail++; $display("FAIL vec_empty64: got %h, required %h", dg, {64'd0, 64'h726fdb47dd0e0e31}); end
    n_checks++; if (lat < 9 || lat > 10) begin n_fail++; $display("FAIL latency: got %0d cycles, required 9..10", lat); end
    msg_q.delete();
    for (int i = 0; i < 15; i++) msg_q.push_back(8'(i));
    run_msg(c_key_std, 1'b0, 1'b0, 1'b0, dg, lat);
    n_checks++; if (dg !== {64'd0, 64'ha129ca6149be45e5}) begin n_fail++; $display("FAIL vec_15b: got %h, required %h", dg, {64'd0, 64'ha129ca6149be45e5}); end
    msg_q.delete();
    run_msg(c_key_std, 1'b1, 1'b0, 1'b0, dg, lat);
    n_checks++; if (dg !== 128'h930255c71472f66d_e6a825ba047f81a3) begin n_fail++; $display("FAIL vec_empty128: got %h, required %h", dg, 128'h930255c71472f66d_e6a825ba047f81a3); end
  endtask

  task automatic test_pad();
    logic [127:0] dg, exp;
    int lat;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      msg_q.delete();
      for (int i = 0; i < 8; i++) msg_q.push_back(8'(i));
      exp = ref_hash(c_key_std, 1'b0, (s == 1) ? 3 : 2, 4);
      run_msg(c_key_std, 1'b0, 1'b0, 1'b0, dg, lat);
      n_checks++; if (dg !== exp) begin n_fail++; $display("FAIL pad8_sel%0d: got %h, required %h", s, dg, exp); end
      for (int i = 8; i < 16; i++) msg_q.push_back(8'(i));
      exp = ref_hash(c_key_std, 1'b1, (s == 1) ? 3 : 2, 4);
      run_msg(c_key_std, 1'b1, 1'b0, 1'b0, dg, lat);
      n_checks++; if (dg !== exp) begin n_fail++; $display("FAIL pad16_long_sel%0d: got %h, required %h", s, dg, exp); end
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] k, dg, exp;
    int lat, n;
    bit lg;
    for (int r = 0; r < 10; r++) begin
      sel = 1'(r % 2);
      k   = {$urandom, $urandom, $urandom, $urandom};
      lg  = 1'($urandom);
      n   = (r == 8) ? 300 : (r == 9) ? 256 : $urandom_range(0, 40);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      exp = ref_hash(k, lg, (r % 2 == 1) ? 3 : 2, 4);
      run_msg(k, lg, 1'b1, 1'b0, dg, lat);
      n_checks++; if (dg !== exp) begin n_fail++; $display("FAIL random_%0d len=%0d long=%0d: got %h, required %h", r, n, lg, dg, exp); end
    end
    sel = 1'b0;
  endtask

  task automatic test_start_ignored();
    logic [127:0] dg, exp;
    int lat;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      msg_q.delete();
      for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
      exp = ref_hash(c_key_std, 1'(s), (s == 1) ? 3 : 2, 4);
      run_msg(c_key_std, 1'(s), 1'b1, 1'b1, dg, lat);
      n_checks++; if (dg !== exp) begin n_fail++; $display("FAIL start_ignored_sel%0d: got %h, required %h", s, dg, exp); end
    end
    sel = 1'b0;
  endtask

  task automatic test_hold_and_abort();
    logic [127:0] dg, exp;
    int lat;
    sel = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
    exp = ref_hash(c_key_std, 1'b0, 2, 4);
    run_msg(c_key_std, 1'b0, 1'b0, 1'b0, dg, lat);
    repeat (5) @(negedge clk);
    n_checks++; if (digest_valid !== 1'b1) begin n_fail++; $display("FAIL hold_dv: got %b, required 1", digest_valid); end
    n_checks++; if (digest !== exp) begin n_fail++; $display("FAIL hold_digest: got %h, required %h", digest, exp); end
    key = c_key_std; long = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL start_clears_dv: got %b, required 0", digest_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b, required 1", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b, required 1", in_ready); end
    in_data = {$urandom, $urandom}; in_last = 1'b1; in_bytes = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_checks++; if (digest !== 128'd0) begin n_fail++; $display("FAIL abort_digest: got %h, required 0", digest); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL abort_dv: got %b, required 0", digest_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b, required 0", in_ready); end
    repeat (12) @(negedge clk);
    n_checks++; if (digest_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: dv=%b busy=%b, required 0 0", digest_valid, busy); end
    msg_q.delete();
    run_msg(c_key_std, 1'b0, 1'b0, 1'b0, dg, lat);
    n_checks++; if (dg !== {64'd0, 64'h726fdb47dd0e0e31}) begin n_fail++; $display("FAIL after_abort: got %h, required %h", dg, {64'd0, 64'h726fdb47dd0e0e31}); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = 4'd0;
    in_data = '0; key = '0; long = 1'b0; sel = 1'b0;
    test_reset();
    test_vectors();
    test_pad();
    test_random();
    test_start_ignored();
    test_hold_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
